// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: per-product stock, motor drive with stall timeout,
// coin-by-coin change payout and restock.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a sale request; restock accepted here only
// MOTOR    | driving motor of latched product, counting toward timeout
// CHANGE   | one-cycle coin eject command
// WAIT_ACK | waiting (unbounded) for hopper acknowledge of the coin
// DONE     | one-cycle sale-complete pulse
// FAULT    | motor stalled; only clr_fault (or rst) leaves
module vend_dispense_ctrl #(
    parameter logic [3:0] STOCK_INIT    = 4'd9,
    parameter logic [7:0] MOTOR_TIMEOUT = 8'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_req,
    input  logic [1:0] vend_sel,
    input  logic [1:0] vend_chg,
    input  logic       motor_done,
    input  logic       coin_ack,
    input  logic       restock,
    input  logic [1:0] restock_sel,
    input  logic [3:0] restock_qty,
    input  logic       clr_fault,
    output logic [3:0] motor_on,
    output logic       coin_eject,
    output logic       busy,
    output logic       vend_done,
    output logic       vend_rej,
    output logic       fault,
    output logic [3:0] sold_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MOTOR    = 3'd1,
        CHANGE   = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] chg_q, chg_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] stock_q [4];
    logic [3:0] stock_d [4];
    logic       rej_q, rej_d;

    logic [4:0] rs_sum;
    logic [7:0] cnt_inc;

    assign rs_sum  = {1'b0, stock_q[restock_sel]} + {1'b0, restock_qty};
    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            chg_q   <= 2'd0;
            cnt_q   <= 8'd0;
            rej_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= STOCK_INIT;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        chg_d   = chg_q;
        cnt_d   = cnt_q;
        rej_d   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stock_d[i] = stock_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (vend_req) begin
                    if (stock_q[vend_sel] == 4'd0) begin
                        rej_d = 1'b1;
                    end else begin
                        sel_d   = vend_sel;
                        chg_d   = vend_chg;
                        cnt_d   = 8'd0;
                        state_d = MOTOR;
                    end
                end else if (restock) begin
                    stock_d[restock_sel] = rs_sum[4] ? 4'd15 : rs_sum[3:0];
                end
            end
            MOTOR: begin
                // cnt_q holds the MOTOR cycles already elapsed before this one
                if (motor_done) begin
                    stock_d[sel_q] = stock_q[sel_q] - 4'd1;
                    state_d        = (chg_q != 2'd0) ? CHANGE : DONE;
                end else if (cnt_inc == MOTOR_TIMEOUT) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CHANGE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (coin_ack) begin
                    chg_d   = chg_q - 2'd1;
                    state_d = (chg_q == 2'd1) ? DONE : CHANGE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (clr_fault) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign motor_on   = (state_q == MOTOR) ? (4'b0001 << sel_q) : 4'b0000;
    assign coin_eject = (state_q == CHANGE);
    assign busy       = (state_q != IDLE);
    assign vend_done  = (state_q == DONE);
    assign vend_rej   = rej_q;
    assign fault      = (state_q == FAULT);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sold_out[i] = (stock_q[i] == 4'd0);
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vend_req = 1'b0;
    logic [1:0] vend_sel = 2'd0;
    logic [1:0] vend_chg = 2'd0;
    logic       motor_done = 1'b0;
    logic       coin_ack = 1'b0;
    logic       restock = 1'b0;
    logic [1:0] restock_sel = 2'd0;
    logic [3:0] restock_qty = 4'd0;
    logic       clr_fault = 1'b0;
    logic [3:0] motor_on;
    logic       coin_eject;
    logic       busy;
    logic       vend_done;
    logic       vend_rej;
    logic       fault;
    logic [3:0] sold_out;

    always #5 clk = ~clk;

    vend_dispense_ctrl dut (
        .clk(clk), .rst(rst), .vend_req(vend_req), .vend_sel(vend_sel),
        .vend_chg(vend_chg), .motor_done(motor_done), .coin_ack(coin_ack),
        .restock(restock), .restock_sel(restock_sel), .restock_qty(restock_qty),
        .clr_fault(clr_fault), .motor_on(motor_on), .coin_eject(coin_eject),
        .busy(busy), .vend_done(vend_done), .vend_rej(vend_rej), .fault(fault),
        .sold_out(sold_out)
    );

    typedef struct packed {
        logic [2:0]  kind;
        logic [11:0] data;
    } ev_t;

    localparam logic [2:0] K_MOTOR = 3'd1;
    localparam logic [2:0] K_EJECT = 3'd2;
    localparam logic [2:0] K_REJ   = 3'd3;
    localparam logic [2:0] K_DONE  = 3'd4;
    localparam logic [2:0] K_FAULT = 3'd5;

    ev_t        exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] stock_m [4];
    logic       mon_en = 1'b0;
    int         run_len = 0;
    logic [3:0] run_oh = 4'd0;
    logic       fault_prev = 1'b0;

    function automatic ev_t mk(input logic [2:0] k, input logic [11:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic got(input ev_t a);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0h with nothing expected (t=%0t)",
                     a.kind, a.data, $time);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL event_order: got kind %0d data %0h expected kind %0d data %0h (t=%0t)",
                         a.kind, a.data, e.kind, e.data, $time);
            end
        end
    endtask

    // Monitor: motor runs are reported as one event {one-hot, length} when they end
    always @(negedge clk) begin
        if (mon_en) begin
            if (motor_on != 4'd0) begin
                if (run_len == 0) run_oh = motor_on;
                run_len++;
            end else if (run_len != 0) begin
                got(mk(K_MOTOR, {run_oh, run_len[7:0]}));
                run_len = 0;
            end
            if (coin_eject) got(mk(K_EJECT, 12'd0));
            if (vend_rej) got(mk(K_REJ, 12'd0));
            if (vend_done) got(mk(K_DONE, 12'd0));
            if (fault && !fault_prev) got(mk(K_FAULT, 12'd0));
            fault_prev = fault;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) stock_m[i] = 4'd9;
    endtask

    task automatic check_stock(input string name);
        for (int i = 0; i < 4; i++) check(name, dut.stock_q[i], stock_m[i]);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, busy, 1'b0);
    endtask

    // Sale with motor_done sampled d cycles after the request and each coin_ack
    // sampled two cycles after its eject.
    task automatic sale(input logic [1:0] sel, input logic [1:0] chg, input int d);
        logic empty;
        empty = (stock_m[sel] == 4'd0);
        if (empty) begin
            exp_q.push_back(mk(K_REJ, 12'd0));
        end else begin
            exp_q.push_back(mk(K_MOTOR, {4'b0001 << sel, 8'(d)}));
            for (int i = 0; i < chg; i++) exp_q.push_back(mk(K_EJECT, 12'd0));
            exp_q.push_back(mk(K_DONE, 12'd0));
        end
        @(negedge clk);
        vend_sel = sel;
        vend_chg = chg;
        vend_req = 1'b1;
        @(negedge clk);
        vend_req = 1'b0;
        if (empty) begin
            @(negedge clk);
            check("rej_stays_idle", busy, 1'b0);
        end else begin
            repeat (d - 1) @(negedge clk);
            motor_done = 1'b1;
            @(negedge clk);
            motor_done = 1'b0;
            stock_m[sel] = stock_m[sel] - 4'd1;
            for (int i = 0; i < chg; i++) begin
                int k = 0;
                while (!coin_eject && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                check("eject_seen", coin_eject, 1'b1);
                @(negedge clk);
                coin_ack = 1'b1;
                @(negedge clk);
                coin_ack = 1'b0;
            end
            wait_idle("sale_to_idle");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_outs", {motor_on, coin_eject, vend_done, vend_rej, fault}, 8'd0);
        check("rst_sold_out", sold_out, 4'd0);
        check_stock("rst_stock");
        mon_en = 1'b1;

        // Sale without change, then with change, then 3 coins on product 3
        sale(2'd2, 2'd0, 3);
        check("stock2_after_sale", dut.stock_q[2], 4'd8);
        sale(2'd0, 2'd2, 2);
        check("stock0_after_sale", dut.stock_q[0], 4'd8);

        // Motor stall on product 3
        exp_q.push_back(mk(K_MOTOR, {4'b1000, 8'd20}));
        exp_q.push_back(mk(K_FAULT, 12'd0));
        @(negedge clk);
        vend_sel = 2'd3;
        vend_chg = 2'd1;
        vend_req = 1'b1;
        @(negedge clk);
        vend_req = 1'b0;
        begin
            int k = 0;
            while (!fault && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        check("fault_set", fault, 1'b1);
        check("fault_outs", {motor_on, coin_eject, vend_done, vend_rej}, 7'd0);
        check("fault_stock3", dut.stock_q[3], 4'd9);
        vend_req = 1'b1;
        motor_done = 1'b1;
        @(negedge clk);
        vend_req = 1'b0;
        motor_done = 1'b0;
        check("fault_holds", fault, 1'b1);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        check("fault_cleared", {busy, fault}, 2'b00);

        sale(2'd3, 2'd3, 5);
        check("stock3_after_sale", dut.stock_q[3], 4'd8);

        // Drain product 1 to sold out, then one more request is rejected
        for (int n = 0; n < 9; n++) sale(2'd1, 2'd0, 1);
        check("sold_out_1", sold_out, 4'b0010);
        sale(2'd1, 2'd0, 1);
        check_stock("stock_after_soldout");

        // Fresh reset, then restock behaviour
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_stock("stock_after_rst");
        restock_sel = 2'd1;
        restock_qty = 4'd10;
        restock = 1'b1;
        @(negedge clk);
        restock_sel = 2'd2;
        restock_qty = 4'd3;
        @(negedge clk);
        restock = 1'b0;
        check("restock_saturate", dut.stock_q[1], 4'd15);
        check("restock_add", dut.stock_q[2], 4'd12);

        // Restock during MOTOR is dropped
        exp_q.push_back(mk(K_MOTOR, {4'b0001, 8'd3}));
        exp_q.push_back(mk(K_DONE, 12'd0));
        vend_sel = 2'd0;
        vend_chg = 2'd0;
        vend_req = 1'b1;
        @(negedge clk);
        vend_req = 1'b0;
        restock_sel = 2'd0;
        restock_qty = 4'd5;
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        @(negedge clk);
        motor_done = 1'b1;
        @(negedge clk);
        motor_done = 1'b0;
        wait_idle("busy_restock_idle");
        check("restock_busy_dropped", dut.stock_q[0], 4'd8);

        // Restock coinciding with vend_req in IDLE loses
        exp_q.push_back(mk(K_MOTOR, {4'b0100, 8'd1}));
        exp_q.push_back(mk(K_DONE, 12'd0));
        @(negedge clk);
        vend_sel = 2'd2;
        vend_req = 1'b1;
        restock_sel = 2'd2;
        restock_qty = 4'd3;
        restock = 1'b1;
        @(negedge clk);
        vend_req = 1'b0;
        restock = 1'b0;
        motor_done = 1'b1;
        @(negedge clk);
        motor_done = 1'b0;
        wait_idle("coincide_idle");
        check("restock_coincide_dropped", dut.stock_q[2], 4'd11);

        // Reset while waiting for a coin acknowledge
        exp_q.push_back(mk(K_MOTOR, {4'b0001, 8'd1}));
        exp_q.push_back(mk(K_EJECT, 12'd0));
        @(negedge clk);
        vend_sel = 2'd0;
        vend_chg = 2'd1;
        vend_req = 1'b1;
        @(negedge clk);
        vend_req = 1'b0;
        motor_done = 1'b1;
        @(negedge clk);
        motor_done = 1'b0;
        @(negedge clk);
        check("in_wait_ack", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midop_rst_busy", busy, 1'b0);
        check("midop_rst_outs", {motor_on, coin_eject, vend_done, vend_rej, fault}, 8'd0);
        model_reset();
        check_stock("midop_rst_stock");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("events_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 Parameter STOCK_INIT, default 4'd9, is the per-product stock loaded at reset.
REQ-002 Parameter MOTOR_TIMEOUT, default 8'd20, is the maximum number of MOTOR cycles allowed without motor_done.
REQ-003 clk  input  1  is the system clock; all logic SHALL be rising-edge triggered.
REQ-004 rst  input  1  is the reset, synchronous and active-high.
REQ-005 vend_req  input  1  is a one-cycle pulse requesting a sale.
REQ-006 vend_sel  input  2  is the product index (0=A .. 3=D), sampled with vend_req.
REQ-007 vend_chg  input  2  is the number of 5-unit change coins owed (0..3), sampled with vend_req.
REQ-008 motor_done  input  1  is the dispense-complete strobe from the product motor.
REQ-009 coin_ack  input  1  is the coin-hopper acknowledge, one pulse per ejected coin.
REQ-010 restock  input  1  is a one-cycle restock pulse.
REQ-011 restock_sel  input  2  is the product index to restock.
REQ-012 restock_qty  input  4  is the quantity to add.
REQ-013 clr_fault  input  1  clears the FAULT state.
REQ-014 motor_on  output  4  is the one-hot motor drive, bit i for product i.
REQ-015 coin_eject  output  1  is a one-cycle eject command to the hopper.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.
REQ-017 vend_done  output  1  is a one-cycle pulse when a sale completes.
REQ-018 vend_rej  output  1  is a one-cycle pulse when a request hits an empty product.
REQ-019 fault  output  1  SHALL be high while in FAULT.
REQ-020 sold_out  output  4  has bit i high whenever stock[i]==0, decoded from registers.

Function
REQ-021 The FSM SHALL have the states IDLE, MOTOR, CHANGE, WAIT_ACK, DONE and FAULT.
REQ-022 Each product SHALL have a 4-bit stock register, stock[0..3].
REQ-023 In IDLE, vend_req with stock[vend_sel]==0 SHALL pulse vend_rej on the next cycle and remain in IDLE.
REQ-024 In IDLE, vend_req with stock[vend_sel]!=0 SHALL latch sel and chg and enter MOTOR on the next cycle.
REQ-025 In MOTOR, motor_on SHALL equal the one-hot of the latched sel, and a cycle counter SHALL start at 0 on entry.
REQ-026 In MOTOR, motor_done SHALL decrement stock[sel] by 1 and transition to CHANGE if chg!=0, otherwise to DONE.
REQ-027 In MOTOR, if the counter reaches MOTOR_TIMEOUT without motor_done, the FSM SHALL enter FAULT, drop motor_on and leave stock unchanged.
REQ-028 motor_done arriving on the timeout cycle SHALL take priority over the timeout.
REQ-029 CHANGE SHALL assert coin_eject for exactly one cycle, then enter WAIT_ACK.
REQ-030 In WAIT_ACK, coin_ack SHALL decrement chg and transition to DONE if chg becomes 0, otherwise to CHANGE.
REQ-031 WAIT_ACK has no timeout; the FSM SHALL wait indefinitely for coin_ack.
REQ-032 DONE SHALL pulse vend_done for one cycle and return to IDLE.
REQ-033 FAULT SHALL hold fault=1 with all other outputs low; clr_fault SHALL return the FSM to IDLE.
REQ-034 vend_req, motor_done and coin_ack SHALL be ignored in any state where they are not consumed.
REQ-035 Restock SHALL be accepted only in IDLE: stock[restock_sel] = min(stock + restock_qty, 15), saturating.
REQ-036 When restock and vend_req coincide in IDLE, vend_req SHALL win and the restock SHALL be dropped.
REQ-037 Restock while busy SHALL be dropped.
REQ-038 There SHALL be no latch-inferred or combinational-loop logic; every output is registered or decoded from registers.

Reset
REQ-039 rst SHALL force, on the next rising edge, the FSM to IDLE and stock[0..3] to STOCK_INIT.
REQ-040 rst SHALL also clear chg, sel and the timeout counter.
REQ-041 rst SHALL force motor_on=0, coin_eject=0, vend_done=0, vend_rej=0 and fault=0.
REQ-042 rst SHALL take precedence over every other input, including mid-dispense and in FAULT.

Verification
REQ-043 Sale without change: rst, then vend_req sel=2 chg=0, motor_done 3 cycles later -> motor_on=4'b0100 for 3 cycles, then vend_done pulse, stock[2]=8.
REQ-044 Sale with change: vend_req sel=0 chg=2, motor_done, and each coin_ack 2 cycles after its eject -> exactly 2 coin_eject pulses, then vend_done pulse, stock[0]=8.
REQ-045 Sold out: 9 sales of product 1, then a 10th request -> sold_out[1]=1, vend_rej pulse, no motor_on.
REQ-046 Timeout: vend_req sel=3 with motor_done never asserted -> fault=1 after 20 MOTOR cycles, stock[3]=9 unchanged, clr_fault returns to IDLE.
REQ-047 Restock: restock sel=1 qty=10 from stock 9 -> stock[1]=15 (saturated); restock while busy leaves stock unchanged.
REQ-048 Reset mid-operation: rst in WAIT_ACK -> next cycle busy=0, all outputs 0, all stock=9.
